// File: rtl/adc_axis_block_averager.sv
// Boxcar-averages 2^LOG2_N paired A/B ADC samples into one AXI-Stream output pair.
// Latency: the result is valid in the cycle after the block's final accepted sample.
// Backpressure: upstream cannot stall; a result completing while the output is held is dropped and flags overrun.
module adc_axis_block_averager #(
    parameter int ADC_WIDTH        = 12,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int LOG2_N           = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic                        clear_overrun,
    input  logic                        s_axis_a_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_a_tdata,
    input  logic                        s_axis_b_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_b_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_a_tdata,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_b_tdata,
    output logic                        overrun
);

    localparam int ACC_W = ADC_WIDTH + LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;

    logic [CNT_W-1:0]     cnt;
    logic [ACC_W-1:0]     acc_a;
    logic [ACC_W-1:0]     acc_b;
    logic [ADC_WIDTH-1:0] smp_a;
    logic [ADC_WIDTH-1:0] smp_b;
    logic [ACC_W-1:0]     sum_a;
    logic [ACC_W-1:0]     sum_b;
    logic [ADC_WIDTH-1:0] avg_a;
    logic [ADC_WIDTH-1:0] avg_b;
    logic                 accept_vld;
    logic                 cnt_last;
    logic                 block_done;
    logic                 slot_rdy;
    logic                 unused_tdata_hi;

    assign smp_a = s_axis_a_tdata[ADC_WIDTH-1:0];
    assign smp_b = s_axis_b_tdata[ADC_WIDTH-1:0];

    // Upper tdata bits carry only zero padding from the ADC stage.
    assign unused_tdata_hi = ^{s_axis_a_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH],
                               s_axis_b_tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH]};

    // A sample pair is taken only when both channels present together.
    assign accept_vld = enable & s_axis_a_tvalid & s_axis_b_tvalid;
    assign cnt_last   = (LOG2_N == 0) ? 1'b1 : (cnt == {CNT_W{1'b1}});
    assign block_done = accept_vld & cnt_last;
    assign slot_rdy   = ~m_axis_tvalid | m_axis_tready;

    assign sum_a = acc_a + ACC_W'(smp_a);
    assign sum_b = acc_b + ACC_W'(smp_b);
    assign avg_a = sum_a[ACC_W-1:LOG2_N];
    assign avg_b = sum_b[ACC_W-1:LOG2_N];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt   <= '0;
            acc_a <= '0;
            acc_b <= '0;
        end else if (!enable || block_done) begin
            cnt   <= '0;
            acc_a <= '0;
            acc_b <= '0;
        end else if (accept_vld) begin
            cnt   <= cnt + CNT_W'(1);
            acc_a <= sum_a;
            acc_b <= sum_b;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid  <= 1'b0;
            m_axis_a_tdata <= '0;
            m_axis_b_tdata <= '0;
        end else if (block_done && slot_rdy) begin
            m_axis_tvalid  <= 1'b1;
            m_axis_a_tdata <= AXIS_TDATA_WIDTH'(avg_a);
            m_axis_b_tdata <= AXIS_TDATA_WIDTH'(avg_b);
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid  <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overrun <= 1'b0;
        end else if (block_done && !slot_rdy) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
